// File: rtl/bit_stream_pkg.sv
// Shared state encoding and default sizing for the bit stream generator.
package bit_stream_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 50000000;
endpackage

// File: rtl/bit_stream_gen_if.sv
// Load/pattern request and serial output bundle for bit_stream_gen.
interface bit_stream_gen_if #(parameter int WIDTH = 8);
  logic             load;
  logic [WIDTH-1:0] data;
  logic             bit_out;
  logic             bit_valid;
  logic             busy;
  logic             done;
  logic [3:0]       cnt;

  modport master (output load, data, input bit_out, bit_valid, busy, done, cnt);
  modport slave  (input load, data, output bit_out, bit_valid, busy, done, cnt);
endinterface

// File: rtl/bit_stream_gen_tick_gen.sv
// Bit-period prescaler: counts 0..DIV-1 while clr is low, tick on DIV-1.
module tick_gen
  import bit_stream_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int PW = $clog2(DIV);

  logic [PW-1:0] pcnt;

  assign tick = (pcnt == PW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst)             pcnt <= '0;
    else if (clr || tick) pcnt <= '0;
    else                  pcnt <= pcnt + PW'(1);
  end
endmodule

// File: rtl/bit_stream_gen.sv
// Serialises a captured WIDTH-bit pattern MSB first, one bit per DIV clocks.
// Define BIT_STREAM_PARITY_EN to append an even-parity bit to each frame.
module bit_stream_gen
  import bit_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV
) (
  input  logic           clk,
  input  logic           rst,
  bit_stream_gen_if.slave bus
);
`ifdef BIT_STREAM_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  state_t          state, state_n;
  logic [FL-1:0]   shreg, shreg_n, capture;
  logic [3:0]      cnt, cnt_n;
  logic            bit_out, bit_out_n;
  logic            bit_valid_n, done_n, busy_n;
  logic            bit_valid, done, busy;
  logic            load_q, tick, clr;

  // Parity rides along as the LSB so plain shifting emits it last.
`ifdef BIT_STREAM_PARITY_EN
  assign capture = {bus.data, ^bus.data};
`else
  assign capture = bus.data;
`endif

  assign clr = (state != SHIFT);

  tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    cnt_n       = cnt;
    bit_out_n   = bit_out;
    bit_valid_n = 1'b0;
    done_n      = 1'b0;
    case (state)
      IDLE: if (bus.load && !load_q) begin
        shreg_n = capture;
        cnt_n   = 4'd0;
        state_n = SHIFT;
      end
      SHIFT: if (tick) begin
        // The tick after the last bit closes out that bit's full period.
        if (cnt == 4'(FL)) begin
          state_n = DONE;
        end else begin
          bit_out_n   = shreg[FL-1];
          shreg_n     = shreg << 1;
          cnt_n       = cnt + 4'd1;
          bit_valid_n = 1'b1;
        end
      end
      DONE: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg     <= '0;
      cnt       <= 4'd0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      bit_out   <= bit_out_n;
      bit_valid <= bit_valid_n;
      done      <= done_n;
      busy      <= busy_n;
      load_q    <= bus.load;
    end
  end

  assign bus.bit_out   = bit_out;
  assign bus.bit_valid = bit_valid;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.cnt       = cnt;
endmodule
